fp_addsub_seq: RTL and testbench
================================

// Module: fp_addsub_seq
// PURPOSE
//   Parametrised IEEE-754 add/subtract unit. This is the successor to the fixed
//   single-precision adder. Exponent and mantissa widths are generic, and an
//   add/sub mode is selected per operation. Operands are accepted with a
//   valid/ready handshake and the result returns after a fixed latency.
//   Rounding is round-to-nearest-even and exception flags are produced.
//   The block sits between the operand register file and the FP result bus.
// PARAMETERS
//   EXP_W  8   exponent field width (bias = 2**(EXP_W-1)-1)
//   MAN_W  23  stored fraction width (hidden bit not included)
//   (W = 1+EXP_W+MAN_W, the total operand width)
// PORTS
//   clock      in   1  rising-edge clock
//   reset      in   1  synchronous, active-high reset
//   in_valid   in   1  operand pair and op are valid
//   in_ready   out  1  block can accept an operation (high only in IDLE)
//   input_a    in   W  operand A
//   input_b    in   W  operand B
//   op_sub     in   1  0: A+B, 1: A-B (flips B's sign at accept)
//   out_valid  out  1  result and flags are valid
//   out_ready  in   1  consumer takes result
//   output_z   out  W  result
//   flag_inv   out  1  invalid operation (NaN operand, or inf-inf)
//   flag_ovf   out  1  result overflowed to infinity
//   flag_inx   out  1  result is inexact (guard|round|sticky nonzero)
// BEHAVIOUR
//   Reset (sync, clock edge with reset=1):
//     state=IDLE, in_ready=1, out_valid=0, output_z=0, all flags=0.
//     Reset aborts any operation in flight; no result is emitted.
//   FSM: IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE
//     IDLE:   accepts an operation on in_valid&&in_ready; latches A, B and op.
//     UNPACK: exp==0 -> effective exp 1, hidden bit 0 (denormal); else hidden bit 1.
//             Mantissas are extended by 3 bits (guard, round, sticky).
//     ALIGN:  one-cycle barrel right-shift of the smaller-exponent mantissa by
//             the exponent difference. The shift is clamped to MAN_W+4. Bits
//             shifted out are ORed into sticky.
//     ADD:    same signs -> add. Otherwise subtract smaller magnitude from larger;
//             sign comes from the larger operand. Sum width is MAN_W+5.
//     NORM:   carry out -> shift right 1 (sticky keeps the lost bit), exp+1.
//             Otherwise shift left by the leading-zero count, limited so that
//             exp does not drop below 1 (gradual underflow to denormal).
//     ROUND:  RNE. Increment when guard && (round|sticky|lsb). A mantissa
//             carry from rounding bumps exp. Exp >= 2**EXP_W-1 -> +/-inf, flag_ovf=1.
//     DONE:   out_valid=1; output_z and flags are held stable until out_ready=1.
//             On that edge: out_valid=0, state=IDLE.
//   Latency: accept edge to out_valid = 6 cycles, fixed for every input class.
//   Special cases are detected in UNPACK and carried through the pipeline.
//   The override is applied at ROUND, so latency is unchanged:
//     NaN operand      -> canonical qNaN (sign 0, exp all 1, MSB fraction 1), flag_inv
//     inf - inf        -> canonical qNaN, flag_inv
//     single inf       -> that inf with its sign
//     exact-zero result -> +0, except (-0)+(-0) = -0
//   No new operation is accepted until the result is consumed; throughput is
//   one operation per 7+ cycles.
//   in_valid while busy is ignored. The source must hold its operands until
//   in_ready is high.
//   Flags belong to the current result only; they clear on the next accept.
//   out_ready high while out_valid=0 has no effect.
// TESTING (EXP_W=8, MAN_W=23 unless stated)
//   1 3F800000 + 40000000 -> 40400000; out_valid exactly 6 cycles after accept; flags 0
//   2 3F800000 - 3F800000 (op_sub=1) -> 00000000; 3F800000 + 33800000 -> 3F800000
//     with flag_inx=1 (tie to even); 3F800000 + 33800001 -> 3F800001, flag_inx=1
//   3 7F7FFFFF + 7F7FFFFF -> 7F800000, flag_ovf=1, flag_inx=1;
//     7F800000 + FF800000 -> 7FC00000, flag_inv=1
//   4 00000001 + 00000001 -> 00000002; 00800000 - 00000001 -> 007FFFFF; flags 0
//   5 Backpressure: hold out_ready=0 for 10 cycles -> output_z and flags stable,
//     in_ready=0, an extra in_valid is ignored
//   6 Reset asserted in ALIGN -> next cycle out_valid=0, in_ready=1, output_z=0;
//     repeat test 1 with EXP_W=11, MAN_W=52: 3FF0...0 + 4000...0 -> 4008000000000000

Source files
------------

// File: rtl/fp_addsub_seq.sv
// Sequential IEEE-754 adder/subtractor with generic exponent/fraction widths.
// One operation at a time walks IDLE->UNPACK->ALIGN->ADD->NORM->ROUND->DONE,
// rounding to nearest-even and raising invalid/overflow/inexact flags.
module fp_addsub_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] input_a,
  input  logic [EXP_W+MAN_W:0] input_b,
  input  logic                 op_sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] output_z,
  output logic                 flag_inv,
  output logic                 flag_ovf,
  output logic                 flag_inx
);
  localparam int W = 1 + EXP_W + MAN_W;
  // working mantissa: hidden bit, fraction, guard, round, sticky
  localparam int M = MAN_W + 4;
  localparam logic [EXP_W-1:0] SH_MAX    = EXP_W'(M);
  localparam logic [EXP_W-1:0] EXP_ONE   = EXP_W'(1);
  localparam logic [EXP_W:0]   EXP_ONE_X = (EXP_W+1)'(1);
  localparam logic [EXP_W:0]   EXP_INF_X = {1'b0, {EXP_W{1'b1}}};

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, DONE} state_t;
  state_t state_reg, state_next;

  logic [W-1:0]     a_reg, b_reg;
  logic             sa_reg, sb_reg;
  logic [EXP_W-1:0] ea_reg, eb_reg;
  logic [M-1:0]     ma_reg, mb_reg;
  logic             spec_nan_reg, spec_inf_reg, spec_sgn_reg;
  logic             sgn_big_reg, sgn_small_reg;
  logic [EXP_W-1:0] exp_big_reg;
  logic [M-1:0]     man_big_reg, man_small_reg;
  logic [M:0]       sum_reg;
  logic             res_sgn_reg;
  logic [EXP_W:0]   res_exp_reg;
  logic [M-1:0]     norm_man_reg;
  logic [EXP_W:0]   norm_exp_reg;

  // leading-zero count; the highest set bit wins because it is visited last
  function automatic logic [EXP_W:0] lzc(input logic [M-1:0] v);
    lzc = (EXP_W+1)'(M);
    for (int i = 0; i < M; i++)
      if (v[i]) lzc = (EXP_W+1)'(M - 1 - i);
  endfunction

  // operand classification used while unpacking
  logic [EXP_W-1:0] a_exp_raw, b_exp_raw;
  logic a_exp_max, b_exp_max, a_nan, b_nan, a_inf, b_inf;
  assign a_exp_raw = a_reg[W-2:MAN_W];
  assign b_exp_raw = b_reg[W-2:MAN_W];
  assign a_exp_max = &a_exp_raw;
  assign b_exp_max = &b_exp_raw;
  assign a_nan = a_exp_max & (|a_reg[MAN_W-1:0]);
  assign b_nan = b_exp_max & (|b_reg[MAN_W-1:0]);
  assign a_inf = a_exp_max & ~(|a_reg[MAN_W-1:0]);
  assign b_inf = b_exp_max & ~(|b_reg[MAN_W-1:0]);

  // alignment: right-shift the smaller-exponent mantissa, folding lost bits into sticky
  logic             a_big;
  logic [EXP_W-1:0] exp_diff, align_sh;
  logic [M-1:0]     small_pre, small_shift, small_mask, small_al;
  always_comb begin
    a_big       = (ea_reg >= eb_reg);
    exp_diff    = a_big ? (ea_reg - eb_reg) : (eb_reg - ea_reg);
    align_sh    = (exp_diff > SH_MAX) ? SH_MAX : exp_diff;
    small_pre   = a_big ? mb_reg : ma_reg;
    small_shift = small_pre >> align_sh;
    small_mask  = ~({M{1'b1}} << align_sh);
    small_al    = {small_shift[M-1:1], small_shift[0] | (|(small_pre & small_mask))};
  end

  // magnitude add/subtract; an exact zero is negative only when both inputs are
  logic [M:0] sum_next;
  logic       sum_sgn;
  always_comb begin
    sum_sgn = sgn_big_reg;
    if (sgn_big_reg == sgn_small_reg) begin
      sum_next = {1'b0, man_big_reg} + {1'b0, man_small_reg};
    end else if (man_big_reg >= man_small_reg) begin
      sum_next = {1'b0, man_big_reg} - {1'b0, man_small_reg};
    end else begin
      sum_next = {1'b0, man_small_reg} - {1'b0, man_big_reg};
      sum_sgn  = sgn_small_reg;
    end
    if (sum_next == '0) sum_sgn = sgn_big_reg & sgn_small_reg;
  end

  // normalisation; the left shift stops at exponent 1 so tiny results stay denormal
  logic [EXP_W:0] lz, lz_lim, norm_sh, norm_exp_next;
  logic [M-1:0]   norm_man_next;
  always_comb begin
    lz      = lzc(sum_reg[M-1:0]);
    lz_lim  = res_exp_reg - EXP_ONE_X;
    norm_sh = (lz < lz_lim) ? lz : lz_lim;
    if (sum_reg[M]) begin
      norm_man_next = {sum_reg[M:2], sum_reg[1] | sum_reg[0]};
      norm_exp_next = res_exp_reg + EXP_ONE_X;
    end else begin
      norm_man_next = sum_reg[M-1:0] << norm_sh;
      norm_exp_next = res_exp_reg - norm_sh;
    end
  end

  // round-to-nearest-even, packing, overflow and special-value override
  logic             rnd_inc, rnd_hid;
  logic [MAN_W+1:0] rnd_man;
  logic [EXP_W:0]   rnd_exp;
  logic [MAN_W-1:0] rnd_frac;
  logic [W-1:0]     z_next;
  logic             inv_next, ovf_next, inx_next;
  always_comb begin
    rnd_inc = norm_man_reg[2] & (norm_man_reg[1] | norm_man_reg[0] | norm_man_reg[3]);
    rnd_man = {1'b0, norm_man_reg[M-1:3]} + {{(MAN_W+1){1'b0}}, rnd_inc};
    if (rnd_man[MAN_W+1]) begin
      rnd_exp  = norm_exp_reg + EXP_ONE_X;
      rnd_frac = rnd_man[MAN_W:1];
      rnd_hid  = 1'b1;
    end else begin
      rnd_exp  = norm_exp_reg;
      rnd_frac = rnd_man[MAN_W-1:0];
      rnd_hid  = rnd_man[MAN_W];
    end
    inv_next = 1'b0;
    ovf_next = 1'b0;
    inx_next = |norm_man_reg[2:0];
    z_next   = {res_sgn_reg, (rnd_hid ? rnd_exp[EXP_W-1:0] : {EXP_W{1'b0}}), rnd_frac};
    if (spec_nan_reg) begin
      z_next   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      inv_next = 1'b1;
      inx_next = 1'b0;
    end else if (spec_inf_reg) begin
      z_next   = {spec_sgn_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      inx_next = 1'b0;
    end else if (rnd_exp >= EXP_INF_X) begin
      z_next   = {res_sgn_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ovf_next = 1'b1;
      inx_next = 1'b1;
    end
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // next-state and handshake outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = UNPACK;
      end
      UNPACK: state_next = ALIGN;
      ALIGN:  state_next = ADD;
      ADD:    state_next = NORM;
      NORM:   state_next = ROUND;
      ROUND:  state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // datapath: each state loads the registers of the next stage
  always_ff @(posedge clock) begin
    if (reset) begin
      output_z <= '0;
      flag_inv <= 1'b0;
      flag_ovf <= 1'b0;
      flag_inx <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          a_reg    <= input_a;
          b_reg    <= {input_b[W-1] ^ op_sub, input_b[W-2:0]};
          flag_inv <= 1'b0;
          flag_ovf <= 1'b0;
          flag_inx <= 1'b0;
        end
        UNPACK: begin
          sa_reg       <= a_reg[W-1];
          sb_reg       <= b_reg[W-1];
          ea_reg       <= (a_exp_raw == '0) ? EXP_ONE : a_exp_raw;
          eb_reg       <= (b_exp_raw == '0) ? EXP_ONE : b_exp_raw;
          ma_reg       <= {|a_exp_raw, a_reg[MAN_W-1:0], 3'b000};
          mb_reg       <= {|b_exp_raw, b_reg[MAN_W-1:0], 3'b000};
          spec_nan_reg <= a_nan | b_nan | (a_inf & b_inf & (a_reg[W-1] ^ b_reg[W-1]));
          spec_inf_reg <= a_inf | b_inf;
          spec_sgn_reg <= a_inf ? a_reg[W-1] : b_reg[W-1];
        end
        ALIGN: begin
          sgn_big_reg   <= a_big ? sa_reg : sb_reg;
          sgn_small_reg <= a_big ? sb_reg : sa_reg;
          exp_big_reg   <= a_big ? ea_reg : eb_reg;
          man_big_reg   <= a_big ? ma_reg : mb_reg;
          man_small_reg <= small_al;
        end
        ADD: begin
          sum_reg     <= sum_next;
          res_sgn_reg <= sum_sgn;
          res_exp_reg <= {1'b0, exp_big_reg};
        end
        NORM: begin
          norm_man_reg <= norm_man_next;
          norm_exp_reg <= norm_exp_next;
        end
        ROUND: begin
          output_z <= z_next;
          flag_inv <= inv_next;
          flag_ovf <= ovf_next;
          flag_inx <= inx_next;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_addsub_seq.sv
// Directed bench for fp_addsub_seq: single precision plus one double-precision instance.
module tb_fp_addsub_seq;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, in_valid, op_sub, out_ready;
  logic [31:0] input_a, input_b;
  logic        in_ready, out_valid, flag_inv, flag_ovf, flag_inx;
  logic [31:0] output_z;

  logic        d_in_valid, d_op_sub, d_out_ready;
  logic [63:0] d_input_a, d_input_b;
  logic        d_in_ready, d_out_valid, d_flag_inv, d_flag_ovf, d_flag_inx;
  logic [63:0] d_output_z;

  int checks = 0;
  int fails  = 0;

  logic [31:0] res_z;
  logic [2:0]  res_flags;
  int          res_cyc;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .input_a(input_a), .input_b(input_b), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .output_z(output_z),
    .flag_inv(flag_inv), .flag_ovf(flag_ovf), .flag_inx(flag_inx)
  );

  fp_addsub_seq #(.EXP_W(11), .MAN_W(52)) u_dut_dp (
    .clock(clock), .reset(reset), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .input_a(d_input_a), .input_b(d_input_b), .op_sub(d_op_sub),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .output_z(d_output_z),
    .flag_inv(d_flag_inv), .flag_ovf(d_flag_ovf), .flag_inx(d_flag_inx)
  );

  // Latency counts rising edges starting with the accept edge until out_valid is seen.
  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input logic sub);
    @(negedge clock);
    input_a = a; input_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clock);
    res_cyc = 1;
    @(negedge clock);
    in_valid = 1'b0;
    while (!out_valid && res_cyc < 20) begin
      @(posedge clock);
      res_cyc++;
      @(negedge clock);
    end
    if (!out_valid) begin
      checks++; fails++;
      $display("FAIL timeout waiting for out_valid: got 0 want 1");
    end
    res_z     = output_z;
    res_flags = {flag_inv, flag_ovf, flag_inx};
    $display("op a=%h b=%h sub=%0d -> z=%h inv/ovf/inx=%b latency=%0d", a, b, sub, res_z, res_flags, res_cyc);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (output_z !== 32'h0) begin fails++; $display("FAIL reset_output_z got %h want 0", output_z); end
    checks++; if ({flag_inv, flag_ovf, flag_inx} !== 3'b000) begin fails++; $display("FAIL reset_flags got %b want 000", {flag_inv, flag_ovf, flag_inx}); end
    checks++; if (d_in_ready !== 1'b1 || d_out_valid !== 1'b0 || d_output_z !== 64'h0) begin
      fails++; $display("FAIL reset_dp got ready=%b valid=%b z=%h want 1 0 0", d_in_ready, d_out_valid, d_output_z);
    end
  endtask

  // table-driven arithmetic: each row is a, b, op_sub, expected z, expected {inv,ovf,inx}
  task automatic run_table(input string name, input logic [31:0] ta[], input logic [31:0] tb[],
                           input logic ts[], input logic [31:0] tz[], input logic [2:0] tf[]);
    for (int i = 0; i < ta.size(); i++) begin
      start_and_wait(ta[i], tb[i], ts[i]);
      checks++; if (res_z !== tz[i]) begin fails++; $display("FAIL %s[%0d] z got %h want %h", name, i, res_z, tz[i]); end
      checks++; if (res_flags !== tf[i]) begin fails++; $display("FAIL %s[%0d] flags got %b want %b", name, i, res_flags, tf[i]); end
      checks++; if (res_cyc !== 6) begin fails++; $display("FAIL %s[%0d] latency got %0d want 6", name, i, res_cyc); end
      consume();
    end
  endtask

  task automatic test_basic();
    run_table("basic", '{32'h3F800000}, '{32'h40000000}, '{1'b0}, '{32'h40400000}, '{3'b000});
  endtask

  task automatic test_rounding();
    run_table("rounding",
      '{32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000},
      '{32'h3F800000, 32'h33800000, 32'h33800001, 32'h3F800000},
      '{1'b1, 1'b0, 1'b0, 1'b1},
      '{32'h00000000, 32'h3F800000, 32'h3F800001, 32'h40000000},
      '{3'b000, 3'b001, 3'b001, 3'b000});
  endtask

  task automatic test_special();
    run_table("special",
      '{32'h7F7FFFFF, 32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7F800000},
      '{32'h7F7FFFFF, 32'hFF800000, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h7F800000},
      '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'hFF800000, 32'h80000000, 32'h7FC00000},
      '{3'b011, 3'b100, 3'b100, 3'b000, 3'b000, 3'b100});
  endtask

  task automatic test_denormal();
    run_table("denormal",
      '{32'h00000001, 32'h00800000, 32'h007FFFFF},
      '{32'h00000001, 32'h00000001, 32'h00000001},
      '{1'b0, 1'b1, 1'b0},
      '{32'h00000002, 32'h007FFFFF, 32'h00800000},
      '{3'b000, 3'b000, 3'b000});
  endtask

  task automatic test_backpressure();
    start_and_wait(32'h3F800000, 32'h40000000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_valid !== 1'b1) begin fails++; $display("FAIL bp_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (output_z !== 32'h40400000) begin fails++; $display("FAIL bp_z[%0d] got %h want 40400000", i, output_z); end
      checks++; if ({flag_inv, flag_ovf, flag_inx} !== 3'b000) begin fails++; $display("FAIL bp_flags[%0d] got %b want 000", i, {flag_inv, flag_ovf, flag_inx}); end
      checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d] got %b want 0", i, in_ready); end
      // a stray request while busy must be ignored
      if (i == 3) begin input_a = 32'h7F800000; input_b = 32'hFF800000; op_sub = 1'b0; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(negedge clock);
    end
    consume();
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        fails++; $display("FAIL bp_after[%0d] got valid=%b ready=%b want 0 1", i, out_valid, in_ready);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset_midflight();
    @(negedge clock);
    input_a = 32'h3F800000; input_b = 32'h40000000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clock);       // accept -> UNPACK
    @(negedge clock);
    in_valid = 1'b0;
    @(posedge clock);       // -> ALIGN
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_valid got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL midreset_ready got %b want 1", in_ready); end
    checks++; if (output_z !== 32'h0) begin fails++; $display("FAIL midreset_z got %h want 0", output_z); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      checks++; if (out_valid !== 1'b0) begin fails++; $display("FAIL midreset_no_result[%0d] got %b want 0", i, out_valid); end
    end
  endtask

  task automatic test_double();
    logic [63:0] va[2] = '{64'h3FF0000000000000, 64'h3FF8000000000000};
    logic [63:0] vb[2] = '{64'h4000000000000000, 64'h3FF8000000000000};
    logic [63:0] vz[2] = '{64'h4008000000000000, 64'h4008000000000000};
    int cyc;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      d_input_a = va[i]; d_input_b = vb[i]; d_op_sub = 1'b0; d_in_valid = 1'b1;
      @(posedge clock);
      cyc = 1;
      @(negedge clock);
      d_in_valid = 1'b0;
      while (!d_out_valid && cyc < 20) begin
        @(posedge clock);
        cyc++;
        @(negedge clock);
      end
      $display("dp op a=%h b=%h -> z=%h latency=%0d", va[i], vb[i], d_output_z, cyc);
      checks++; if (d_output_z !== vz[i]) begin fails++; $display("FAIL dp[%0d] z got %h want %h", i, d_output_z, vz[i]); end
      checks++; if (cyc !== 6) begin fails++; $display("FAIL dp[%0d] latency got %0d want 6", i, cyc); end
      checks++; if ({d_flag_inv, d_flag_ovf, d_flag_inx} !== 3'b000) begin
        fails++; $display("FAIL dp[%0d] flags got %b want 000", i, {d_flag_inv, d_flag_ovf, d_flag_inx});
      end
      d_out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      d_out_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; op_sub = 1'b0; out_ready = 1'b0;
    input_a = '0; input_b = '0;
    d_in_valid = 1'b0; d_op_sub = 1'b0; d_out_ready = 1'b0;
    d_input_a = '0; d_input_b = '0;
    test_reset();
    test_basic();
    test_rounding();
    test_special();
    test_denormal();
    test_backpressure();
    test_reset_midflight();
    test_double();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog expired");
  end
endmodule
